// File: rtl/midi_uart_parser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | midi_uart_parser_if : MIDI serial input and decoded note-control outputs |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface midi_uart_parser_if;
  logic       midi_in;
  logic       gate;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [9:0] amp;
  logic       note_strobe;
  logic       frame_err;

  modport master (
    output midi_in,
    input  gate, note, velocity, amp, note_strobe, frame_err
  );

  modport slave (
    input  midi_in,
    output gate, note, velocity, amp, note_strobe, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/midi_uart_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | midi_uart_parser : 8N1 MIDI receiver and last-note monophonic decoder    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module midi_uart_parser #(
  parameter int CLKSPEED = 48_000_000,
  parameter int BAUD     = 31250,
  parameter int CHANNEL  = 0,
  parameter int OMNI     = 0
) (
  input  logic              clk,
  input  logic              rst,
  midi_uart_parser_if.slave bus_io
);

  localparam int BITCLKS = CLKSPEED / BAUD;
  localparam int CW      = $clog2(BITCLKS);
  localparam logic [CW-1:0] c_half_end = CW'(BITCLKS / 2 - 1);
  localparam logic [CW-1:0] c_bit_end  = CW'(BITCLKS - 1);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    RS_NONE     = 3'd0,
    RS_NOTE_ON  = 3'd1,
    RS_NOTE_OFF = 3'd2,
    RS_SKIP1    = 3'd3,
    RS_SKIP2    = 3'd4
  } rs_t;

  logic          s1_q, s2_q, prev_q;
  rx_state_t     rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          fe_q, fe_d;
  logic          rx_valid;

  rs_t           rs_q, rs_d;
  logic          ph_q, ph_d;
  logic [6:0]    d1_q, d1_d;
  logic          gate_q, gate_d;
  logic [6:0]    note_q, note_d;
  logic [6:0]    vel_q, vel_d;
  logic [9:0]    amp_q, amp_d;
  logic          strobe_q, strobe_d;
  logic          acc;

  assign acc = (OMNI != 0) || (sh_q[3:0] == 4'(CHANNEL));

  // Receiver: all sample points are counted from the synchronized falling edge
  always_comb begin
    rx_d     = rx_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    sh_d     = sh_q;
    fe_d     = 1'b0;
    rx_valid = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) rx_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == c_half_end) begin
          cnt_d = '0;
          bit_d = 3'd0;
          rx_d  = s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == c_bit_end) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == c_bit_end) begin
          cnt_d = '0;
          if (s2_q) begin
            rx_valid = 1'b1;
            rx_d     = RX_IDLE;
          end else begin
            fe_d = 1'b1;
            rx_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (s2_q) rx_d = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // Parser: running status, realtime bytes pass through without side effects
  always_comb begin
    rs_d     = rs_q;
    ph_d     = ph_q;
    d1_d     = d1_q;
    gate_d   = gate_q;
    note_d   = note_q;
    vel_d    = vel_q;
    strobe_d = 1'b0;
    if (rx_valid) begin
      if (sh_q[7:4] == 4'hF) begin
        if (!sh_q[3]) rs_d = RS_NONE;
      end else if (sh_q[7]) begin
        ph_d = 1'b0;
        if (acc && sh_q[7:4] == 4'h9)                rs_d = RS_NOTE_ON;
        else if (acc && sh_q[7:4] == 4'h8)           rs_d = RS_NOTE_OFF;
        else if (sh_q[7:4] == 4'hC || sh_q[7:4] == 4'hD) rs_d = RS_SKIP1;
        else                                         rs_d = RS_SKIP2;
      end else if (rs_q == RS_NOTE_ON || rs_q == RS_NOTE_OFF || rs_q == RS_SKIP2) begin
        ph_d = ~ph_q;
        if (!ph_q) begin
          d1_d = sh_q[6:0];
        end else if (rs_q == RS_NOTE_ON && sh_q[6:0] != 7'd0) begin
          note_d   = d1_q;
          vel_d    = sh_q[6:0];
          gate_d   = 1'b1;
          strobe_d = 1'b1;
        end else if (rs_q != RS_SKIP2 && d1_q == note_q && gate_q) begin
          gate_d   = 1'b0;
          strobe_d = 1'b1;
        end
      end
    end
    amp_d = gate_d ? {vel_d, vel_d[6:4]} : 10'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      prev_q   <= 1'b1;
      rx_q     <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      sh_q     <= 8'd0;
      fe_q     <= 1'b0;
      rs_q     <= RS_NONE;
      ph_q     <= 1'b0;
      d1_q     <= 7'd0;
      gate_q   <= 1'b0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      amp_q    <= 10'd0;
      strobe_q <= 1'b0;
    end else begin
      s1_q     <= bus_io.midi_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      fe_q     <= fe_d;
      rs_q     <= rs_d;
      ph_q     <= ph_d;
      d1_q     <= d1_d;
      gate_q   <= gate_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      amp_q    <= amp_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus_io.gate        = gate_q;
  assign bus_io.note        = note_q;
  assign bus_io.velocity    = vel_q;
  assign bus_io.amp         = amp_q;
  assign bus_io.note_strobe = strobe_q;
  assign bus_io.frame_err   = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_uart_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_midi_uart_parser : scoreboard bench, channel-0 and omni instances     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_midi_uart_parser;
  localparam int CLKSPEED = 1_000_000;
  localparam int BAUD     = 31250;
  localparam int BT       = CLKSPEED / BAUD;

  typedef struct packed {
    logic       fe;
    logic       g;
    logic [6:0] n;
    logic [6:0] v;
  } ev_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;
  always #5 clk = ~clk;

  midi_uart_parser_if bus0();
  midi_uart_parser_if bus1();
  assign bus0.midi_in = line;
  assign bus1.midi_in = line;

  midi_uart_parser #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .CHANNEL(0), .OMNI(0)) dut0 (
    .clk(clk), .rst(rst), .bus_io(bus0));
  midi_uart_parser #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .CHANNEL(0), .OMNI(1)) dut1 (
    .clk(clk), .rst(rst), .bus_io(bus1));

  logic [1:0] o_gate, o_str, o_fe;
  logic [6:0] o_note [2];
  logic [6:0] o_vel  [2];
  logic [9:0] o_amp  [2];
  assign o_gate = {bus1.gate, bus0.gate};
  assign o_str  = {bus1.note_strobe, bus0.note_strobe};
  assign o_fe   = {bus1.frame_err, bus0.frame_err};
  assign o_note[0] = bus0.note;     assign o_note[1] = bus1.note;
  assign o_vel[0]  = bus0.velocity; assign o_vel[1]  = bus1.velocity;
  assign o_amp[0]  = bus0.amp;      assign o_amp[1]  = bus1.amp;

  int checks   = 0;
  int failures = 0;

  // Reference model: messages are collected as a list of data bytes of the
  // length the current running status demands, then executed as a whole.
  int  kind [2];  // 0 none, 1 note-on, 2 note-off, 3 skipped message
  int  mlen [2];
  int  have [2];
  int  d1m  [2];
  bit  gm   [2];
  int  nm   [2];
  int  vm   [2];
  ev_t q [2][$];

  function automatic int amp_of(bit g, int v);
    return g ? (v * 8 + v / 16) : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      kind[k] = 0; mlen[k] = 0; have[k] = 0; d1m[k] = 0;
      gm[k] = 1'b0; nm[k] = 0; vm[k] = 0;
      q[k].delete();
    end
  endtask

  task automatic model_byte(int k, int b);
    int hi, d2;
    bit ok;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      kind[k] = 0; have[k] = 0;
      return;
    end
    if (b >= 'h80) begin
      hi = b / 16;
      ok = (k == 1) || ((b % 16) == 0);
      have[k] = 0;
      mlen[k] = 2;
      if (ok && hi == 9)       kind[k] = 1;
      else if (ok && hi == 8)  kind[k] = 2;
      else begin
        kind[k] = 3;
        if (hi == 'hC || hi == 'hD) mlen[k] = 1;
      end
      return;
    end
    if (kind[k] == 0) return;
    have[k]++;
    if (have[k] == 1) d1m[k] = b;
    if (have[k] < mlen[k]) return;
    have[k] = 0;
    if (kind[k] == 3) return;
    d2 = b;
    if (kind[k] == 1 && d2 != 0) begin
      nm[k] = d1m[k]; vm[k] = d2; gm[k] = 1'b1;
      q[k].push_back('{fe: 1'b0, g: 1'b1, n: 7'(nm[k]), v: 7'(vm[k])});
    end else if (d1m[k] == nm[k] && gm[k]) begin
      gm[k] = 1'b0;
      q[k].push_back('{fe: 1'b0, g: 1'b0, n: 7'(nm[k]), v: 7'(vm[k])});
    end
  endtask

  // Monitor: every strobe or frame error must match the next queued expectation
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (o_str[k] || o_fe[k]) begin
          chk($sformatf("strobe_and_frame_err_together_dut%0d", k), int'(o_str[k] & o_fe[k]), 0);
          chk($sformatf("event_expected_dut%0d", k), int'(q[k].size() > 0), 1);
          if (q[k].size() > 0) begin
            e = q[k].pop_front();
            chk($sformatf("frame_err_dut%0d", k), int'(o_fe[k]), int'(e.fe));
            chk($sformatf("note_strobe_dut%0d", k), int'(o_str[k]), int'(!e.fe));
            if (!e.fe) begin
              chk($sformatf("ev_gate_dut%0d", k), int'(o_gate[k]), int'(e.g));
              chk($sformatf("ev_note_dut%0d", k), int'(o_note[k]), int'(e.n));
              chk($sformatf("ev_vel_dut%0d", k), int'(o_vel[k]), int'(e.v));
              chk($sformatf("ev_amp_dut%0d", k), int'(o_amp[k]), amp_of(e.g, int'(e.v)));
            end
          end
        end
      end
    end
  end

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_gate_dut%0d", tag, k), int'(o_gate[k]), int'(gm[k]));
      chk($sformatf("%s_note_dut%0d", tag, k), int'(o_note[k]), nm[k]);
      chk($sformatf("%s_vel_dut%0d", tag, k), int'(o_vel[k]), vm[k]);
      chk($sformatf("%s_amp_dut%0d", tag, k), int'(o_amp[k]), amp_of(gm[k], vm[k]));
      chk($sformatf("%s_pending_dut%0d", tag, k), q[k].size(), 0);
    end
  endtask

  task automatic send_byte(logic [7:0] b, bit stop_ok);
    @(negedge clk);
    line = 1'b0;
    wait_clks(BT);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      wait_clks(BT);
    end
    for (int k = 0; k < 2; k++) begin
      if (stop_ok) model_byte(k, int'(b));
      else q[k].push_back('{fe: 1'b1, g: 1'b0, n: 7'd0, v: 7'd0});
    end
    line = stop_ok;
    wait_clks(BT);
    if (!stop_ok) begin
      line = 1'b1;
      wait_clks(BT);
    end
    for (int k = 0; k < 2; k++)
      chk($sformatf("byte_%02h_events_drained_dut%0d", b, k), q[k].size(), 0);
  endtask

  task automatic send_seq(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, int n);
    send_byte(b0, 1'b1);
    if (n > 1) send_byte(b1, 1'b1);
    if (n > 2) send_byte(b2, 1'b1);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 15) return 8'h90 | (($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'h00);
    if (r < 25) return 8'h80 | (($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'h00);
    if (r < 30) return 8'hF8 + 8'($urandom_range(0, 7));
    if (r < 33) return 8'hF0 + 8'($urandom_range(0, 7));
    if (r < 40) return 8'($urandom_range('hA0, 'hEF));
    if (r < 55) return 8'h00;
    if (r < 85) return 8'h3C + 8'($urandom_range(0, 3));
    return 8'($urandom_range(0, 127));
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog_timeout actual=%0d required=0", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1; line = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(10 * BT);
    chk("reset_gate", int'(o_gate[0]), 0);
    chk("reset_amp", int'(o_amp[0]), 0);
    check_state("reset_idle");

    send_seq(8'h90, 8'h3C, 8'h64, 3);
    chk("noteon_note", int'(o_note[0]), 'h3C);
    chk("noteon_amp", int'(o_amp[0]), 806);
    send_seq(8'h40, 8'h7F, 8'h00, 2);
    chk("running_note", int'(o_note[0]), 'h40);
    chk("running_amp", int'(o_amp[0]), 1023);
    send_seq(8'h3C, 8'h00, 8'h00, 2);
    check_state("offother");
    send_seq(8'h40, 8'h00, 8'h00, 2);
    chk("release_gate", int'(o_gate[0]), 0);
    chk("release_amp", int'(o_amp[0]), 0);

    send_seq(8'h90, 8'hF8, 8'h45, 3);
    send_seq(8'hFE, 8'h20, 8'h00, 2);
    chk("realtime_note", int'(o_note[0]), 'h45);
    chk("realtime_amp", int'(o_amp[0]), 258);

    @(negedge clk);
    line = 1'b0;
    wait_clks(BT / 4);
    line = 1'b1;
    wait_clks(2 * BT);
    check_state("glitch");

    send_seq(8'h91, 8'h3C, 8'h64, 3);
    chk("chfilter_note_dut0", int'(o_note[0]), 'h45);
    chk("omni_note_a", int'(o_note[1]), 'h3C);
    send_seq(8'h3D, 8'h10, 8'h00, 2);
    chk("omni_note_b", int'(o_note[1]), 'h3D);
    check_state("chfilter");

    send_seq(8'h90, 8'h3C, 8'h64, 3);
    send_byte(8'h55, 1'b0);
    check_state("frame_err");
    send_seq(8'h80, 8'h3C, 8'h40, 3);
    chk("fe_release_gate", int'(o_gate[0]), 0);

    send_seq(8'h90, 8'h3E, 8'h30, 3);
    @(negedge clk);
    line = 1'b0;
    wait_clks(3 * BT + BT / 2);
    rst = 1'b1;
    line = 1'b1;
    wait_clks(4);
    model_reset();
    rst = 1'b0;
    wait_clks(3 * BT);
    check_state("midframe_reset");

    for (int n = 0; n < 100; n++) begin
      send_byte(rand_byte(), $urandom_range(0, 29) != 0);
      wait_clks($urandom_range(0, BT));
      if (n % 10 == 9) check_state("random");
    end
    wait_clks(2 * BT);
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
